load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the word-wide data-memory interface (addr/write_data/mem_read/mem_write/read_data).
//  Accepts one core load/store request at a time. Issues word-aligned memory accesses.
//  Extracts and sign/zero-extends byte and half loads. Performs read-modify-write for SB/SH,
//  because the memory writes whole words only. Sits between the execute stage and the data memory.
// PARAMETERS
//  ADDR_W        32  core address width; memory word index = addr[ADDR_W-1:2]
//  MISALIGN_ERR  1   1: misaligned LH/LW/SH/SW return err with no memory access; 0: low address bits forced to 0
// PORTS
//  clk            in   1   single clock, all state updates on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  req_valid      in   1   core request present
//  req_ready      out  1   1 only in IDLE; handshake = req_valid & req_ready
//  req_store      in   1   1=store, 0=load
//  req_funct3     in   3   RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   ADDR_W  byte address
//  req_wdata      in   32  store data; uses low byte/half/word per funct3
//  resp_valid     out  1   one-cycle pulse, no backpressure
//  resp_rdata     out  32  extended load result; 0 for stores and errors
//  resp_err       out  1   valid with resp_valid: misaligned or illegal funct3
//  mem_addr       out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
//  mem_write_data out  32  full word to memory
//  mem_read       out  1   memory read enable; read_data is combinational
//  mem_write      out  1   memory write enable; memory writes on the posedge
//  mem_read_data  in   32  memory read data
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
//   mem_read=0, mem_write=0, mem_addr=0, mem_write_data=0.
//  On the handshake edge, latch store, funct3, addr and wdata into registers. The core may change inputs afterwards.
//  FSM: IDLE, LD, ST, RMW_RD, RMW_WR, RESP.
//   IDLE   -> RESP if error; LD if load; ST if SW; RMW_RD if SB/SH.
//   LD     mem_read=1. Capture mem_read_data at the edge, extract lanes, -> RESP.
//   ST     mem_write=1, mem_write_data=wdata. Memory written at the edge, -> RESP.
//   RMW_RD mem_read=1. Capture the old word, -> RMW_WR.
//   RMW_WR mem_write=1, mem_write_data = old word with byte/half lane replaced, -> RESP.
//   RESP   resp_valid=1 for one cycle, -> IDLE.
//  mem_read, mem_write and mem_addr are decoded from state and registers only, never from req_* ports.
//  mem_read and mem_write are never both 1.
//  Latency from the handshake edge to resp_valid high:
//   load or SW: 2 cycles; SB/SH: 3 cycles; error: 1 cycle.
//  Lane select: byte = addr[1:0]*8; half = addr[1]*16.
//   B and H loads sign-extend from the top bit of the lane. BU and HU zero-extend.
//  Misaligned: H with addr[0]=1; W with addr[1:0]!=0. B is never misaligned.
//  Illegal funct3: 011, 110, 111; 100 or 101 with req_store=1.
//   Errors never assert mem_read or mem_write. resp_rdata=0.
//  With MISALIGN_ERR=0, misaligned accesses are treated as aligned to the lane boundary, and err=0.
//  The next request is accepted in the cycle after RESP. Back-to-back throughput is one request per 3/4 cycles.
//  Reset mid-operation: mem_write/mem_read drop immediately. A write whose edge coincides with
//   rst_n low does not occur. No resp_valid is issued for the aborted request.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state encoding.
//  Sub-module lsu_align (combinational): extract+extend for loads and lane merge for stores.
//   Shared by LD and RMW_WR. The FSM and registers stay in load_store_unit.
// TESTING
//  Bench memory model: 256 words, combinational read, posedge write. Scoreboard compares memory contents.
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF.
//   Response 2 cycles after each handshake. One mem_write pulse total.
//  2 Word @0x20 = 0x80FF7F01:
//   LB @0x21 -> 0x0000007F; LB @0x22 -> 0xFFFFFFFF;
//   LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x22 -> 0x000080FF.
//  3 Word @0x30 = 0x11223344:
//   SB 0xAA @0x31 -> word 0x1122AA44; then SH 0xBEEF @0x32 -> word 0xBEEFAA44.
//   Each takes 3 cycles, with one read then one write.
//  4 LW @0x41, SH @0x43, funct3=011, SBU (store 100) -> each gives resp_err=1 and rdata=0 after 1 cycle.
//   mem_read and mem_write stay 0. Memory unchanged.
//  5 req_valid held high with changing requests -> req_ready=0 outside IDLE.
//   Only latched values are used. Requests complete in order with the correct results.
//  6 Assert rst_n low during RMW_WR of SB @0x50 (old 0x12345678) -> word stays 0x12345678.
//   No resp_valid. All outputs at reset values. The next request works normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM states.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD     = 3'd1,
        S_ST     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit (combinational).
//   funct3    : width code of the access
//   offset    : byte offset inside the word (already forced aligned for H/W)
//   word      : memory word (read data for loads, captured old word for RMW)
//   wdata     : store data, low byte/half/word used
//   load_data : lane extracted and sign/zero-extended
//   merged    : word with the store lane replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [4:0]      byte_sh;
    logic [4:0]      half_sh;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;

    // Load extraction and extension
    always_comb begin
        byte_sh   = {offset, 3'b000};
        half_sh   = {offset[1], 4'b0000};
        byte_lane = word[byte_sh +: 8];
        half_lane = word[half_sh +: 16];
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            default: load_data = word;
        endcase
    end

    // Store lane merge: only the addressed lane takes new data
    always_comb begin
        mask = '1;
        ins  = wdata;
        case (funct3)
            F3_B: begin
                mask = 32'h0000_00FF << byte_sh;
                ins  = XLEN'(wdata[7:0]) << byte_sh;
            end
            F3_H: begin
                mask = 32'h0000_FFFF << half_sh;
                ins  = XLEN'(wdata[15:0]) << half_sh;
            end
            default: begin
                mask = '1;
                ins  = wdata;
            end
        endcase
        merged = (word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one core request at a time, word-wide data memory.
//   req_*  : core request (valid/ready handshake, store flag, funct3, addr, wdata)
//   resp_* : one-cycle response pulse with extended load data and error flag
//   mem_*  : word-aligned memory port; SB/SH go through read-modify-write
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter bit          MISALIGN_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [XLEN-1:0]   mem_read_data
);

    state_t              state;
    state_t              state_nxt;
    logic                store_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     old_q;
    logic [XLEN-1:0]     rdata_q;
    logic                err_q;

    logic                hs;
    logic                illegal;
    logic                misalign;
    logic                req_err;
    logic [ADDR_W-1:0]   addr_fix;
    logic [XLEN-1:0]     align_word;
    logic [XLEN-1:0]     load_data;
    logic [XLEN-1:0]     merged;

    assign hs = req_valid & req_ready;

    // Request classification; misaligned H/W addresses are snapped to the lane boundary
    always_comb begin
        illegal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = req_store;
            default:          illegal = 1'b1;
        endcase
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err  = illegal | (MISALIGN_ERR & misalign);
        addr_fix = req_addr;
        if (req_funct3[1:0] == 2'b01) addr_fix[0]   = 1'b0;
        if (req_funct3[1:0] == 2'b10) addr_fix[1:0] = 2'b00;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    if (req_err)                  state_nxt = S_RESP;
                    else if (!req_store)          state_nxt = S_LD;
                    else if (req_funct3 == F3_W)  state_nxt = S_ST;
                    else                          state_nxt = S_RMW_RD;
                end
            end
            S_LD, S_ST, S_RMW_WR: state_nxt = S_RESP;
            S_RMW_RD:             state_nxt = S_RMW_WR;
            S_RESP:               state_nxt = S_IDLE;
            default:              state_nxt = S_IDLE;
        endcase
    end

    // State and request/data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                store_q <= req_store;
                f3_q    <= req_funct3;
                addr_q  <= addr_fix;
                wdata_q <= req_wdata;
            end
            if (state == S_RMW_RD) old_q <= mem_read_data;
            // Holds load data only through RESP; zero otherwise
            rdata_q <= ((state == S_LD) && !store_q) ? load_data : '0;
            err_q   <= hs & req_err;
        end
    end

    // Loads extract from live read data; RMW merges into the captured old word
    assign align_word = (state == S_LD) ? mem_read_data : old_q;

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .word      (align_word),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Interface outputs decoded from state and latched registers only
    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = (state == S_RESP);
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign mem_read       = (state == S_LD) || (state == S_RMW_RD);
    assign mem_write      = (state == S_ST) || (state == S_RMW_WR);
    assign mem_addr       = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_write_data = (state == S_ST)     ? wdata_q :
                            (state == S_RMW_WR) ? merged  : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 256-word memory, reference model of memory and
// responses, per-cycle compare process, directed cases plus random traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          due;
        int          lat;
        int          reads;
        int          writes;
        int          widx;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] waddr;
        logic [31:0] newword;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    bit          hold = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            8:       return 32'h80FF7F01;
            12:      return 32'h11223344;
            20:      return 32'h12345678;
            default: return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    // Memory model: combinational read, posedge write
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Reference: what a request must do, from width/alignment rules and byte arithmetic
    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          size;
        int          sh;
        logic [63:0] m;
        logic [63:0] v;
        logic [31:0] old;
        e = '{default: 0};
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.widx    = int'(addr[9:2]);
        e.waddr   = {addr[31:2], 2'b00};
        old       = ref_mem[e.widx];
        e.newword = old;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3 >= 3'd4) ||
            (int'(addr[1:0]) % size) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        sh = 8 * int'(addr[1:0]);
        m  = (64'd1 << (8 * size)) - 64'd1;
        if (!st) begin
            v = (64'(old) >> sh) & m;
            if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~m;
            e.rdata = v[31:0];
            e.lat   = 2;
            e.reads = 1;
        end else begin
            e.writes = 1;
            if (size == 4) begin
                e.newword = wd;
                e.lat     = 2;
            end else begin
                e.newword = 32'((64'(old) & ~(m << sh)) | ((64'(wd) & m) << sh));
                e.lat     = 3;
                e.reads   = 1;
            end
        end
        return e;
    endfunction

    // Compare process: checks the DUT against the expectation queue every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            chk1("req_ready", req_ready, q.size() == 0);
            chk1("rd_wr_exclusive", mem_read & mem_write, 1'b0);
            if (mem_read || mem_write) begin
                if (q.size() == 0) chk1("mem_access_idle", mem_read | mem_write, 1'b0);
                else chk("mem_addr", mem_addr, q[0].waddr);
                rd_cnt += int'(mem_read);
                wr_cnt += int'(mem_write);
            end
            if (q.size() != 0 && cyc == q[0].due) begin
                chk1("resp_valid", resp_valid, 1'b1);
                chk1("resp_err", resp_err, q[0].err);
                chk("resp_rdata", resp_rdata, q[0].rdata);
                chk("mem_reads", 32'(rd_cnt), 32'(q[0].reads));
                chk("mem_writes", 32'(wr_cnt), 32'(q[0].writes));
                chk("mem_word", mem[q[0].widx], ref_mem[q[0].widx]);
                void'(q.pop_front());
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                chk1("resp_valid_quiet", resp_valid, 1'b0);
            end
        end
    end

    task automatic drive_idle();
        if (hold) begin
            req_valid  = 1'b1;
            req_store  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom & 32'h3FF;
            req_wdata  = $urandom;
        end else begin
            req_valid = 1'b0;
        end
    endtask

    // Issue one request; called and returns at a negedge
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit pin, input logic [31:0] pin_rdata,
                        input logic pin_err, input int pin_lat);
        exp_t e;
        int   h;
        int   waitc = 0;
        while (!req_ready) begin
            if (waitc > 20) begin
                n_checks++;
                $display("FAIL ready_timeout: req_ready still 0 after %0d cycles", waitc);
                req_valid = 1'b0;
                return;
            end
            drive_idle();
            @(negedge clk);
            waitc++;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        e = model(st, f3, addr, wd);
        if (pin) begin
            chk("pin_rdata", e.rdata, pin_rdata);
            chk1("pin_err", e.err, pin_err);
            chk("pin_latency", 32'(e.lat), 32'(pin_lat));
        end
        h = cyc;
        @(posedge clk);
        e.due = h + e.lat;
        q.push_back(e);
        if (!e.err && st) ref_mem[e.widx] = e.newword;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL resp_timeout: %0d responses outstanding", q.size());
            q.delete();
        end
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_req_ready"}, req_ready, 1'b1);
        chk1({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk1({tag, "_resp_err"}, resp_err, 1'b0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 1: SW then LW
        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2);
        send(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
        wait_drain();

        // 2: byte/half extraction from 0x80FF7F01
        send(1'b0, 3'b000, 32'h21, 32'h0, 1'b1, 32'h0000007F, 1'b0, 2);
        send(1'b0, 3'b000, 32'h22, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 2);
        send(1'b0, 3'b100, 32'h23, 32'h0, 1'b1, 32'h00000080, 1'b0, 2);
        send(1'b0, 3'b001, 32'h22, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, 2);
        send(1'b0, 3'b101, 32'h22, 32'h0, 1'b1, 32'h000080FF, 1'b0, 2);
        wait_drain();

        // 3: SB and SH read-modify-write on 0x11223344
        send(1'b1, 3'b000, 32'h31, 32'h000000AA, 1'b1, 32'h0, 1'b0, 3);
        wait_drain();
        chk("t3_sb_word", mem[12], 32'h1122AA44);
        send(1'b1, 3'b001, 32'h32, 32'h0000BEEF, 1'b1, 32'h0, 1'b0, 3);
        wait_drain();
        chk("t3_sh_word", mem[12], 32'hBEEFAA44);

        // 4: errors
        send(1'b0, 3'b010, 32'h41, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        send(1'b1, 3'b001, 32'h43, 32'h1234, 1'b1, 32'h0, 1'b1, 1);
        send(1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        send(1'b1, 3'b100, 32'h40, 32'h55, 1'b1, 32'h0, 1'b1, 1);
        wait_drain();

        // 6: reset during RMW_WR of SB @0x50
        @(negedge clk);
        send(1'b1, 3'b000, 32'h50, 32'h000000EE, 1'b1, 32'h0, 1'b0, 3);
        @(negedge clk);
        #1 chk1("abort_at_rmw_wr", mem_write, 1'b1);
        rst_n = 1'b0;
        q.delete();
        ref_mem[20] = 32'h12345678;
        #1 chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        chk1("abort_no_resp", resp_valid, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_word", mem[20], 32'h12345678);
        send(1'b0, 3'b010, 32'h50, 32'h0, 1'b1, 32'h12345678, 1'b0, 2);
        wait_drain();

        // 5 + random: req_valid held high with junk while busy
        hold = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [2:0] f3;
            logic [31:0] a;
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2) + ($urandom_range(0, 1) * 4))
                                            : 3'($urandom);
            a  = $urandom & 32'h3FF;
            send(1'($urandom), f3, a, $urandom, 1'b0, 32'h0, 1'b0, 0);
        end
        hold = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
